// File: rtl/register_file.sv
// register_file: 32 x N-bit register file, one write port, two independent read ports.
// Latency: writes commit on the rising clk edge; reads are combinational (0 cycles).
// Backpressure: none; a write is accepted on every clk edge where wr_ena=1 and rst=0.
//
// Ports:
//   clk                  - sole clock, all state updates on its rising edge
//   rst                  - asynchronous active-high reset, clears every register
//   wr_ena/wr_addr/wr_data - write port; writes to x00 are dropped
//   rd_addr0/rd_data0    - read port 0
//   rd_addr1/rd_data1    - read port 1
//
// Optional feature: define REGFILE_BYPASS_EN to forward wr_data onto a read
// port in the same cycle as the write to the register being read.
module register_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [4:0]   rd_addr1,
  output logic [N-1:0] rd_data1
);

  // x00 has no storage; only x01..x31 are real flops.
  logic [N-1:0] regs_q [1:31];
  logic [N-1:0] regs_d [1:31];

  // One-hot write select; bit 0 is never generated so x00 writes vanish here.
  logic [31:1]  wr_sel;

  // Full 32-entry read view with x00 tied to zero, so read muxes index 0-31 directly.
  logic [N-1:0] rf_view [0:31];

  logic [N-1:0] rd_store0;
  logic [N-1:0] rd_store1;

  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < 32; i++) begin
      wr_sel[i] = wr_ena && (wr_addr == 5'(i));
    end
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = wr_sel[i] ? wr_data : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  assign rd_store0 = rf_view[rd_addr0];
  assign rd_store1 = rf_view[rd_addr1];

`ifdef REGFILE_BYPASS_EN
  // Same-cycle forwarding, evaluated per port. x00 and reset never forward.
  logic fwd_ok;
  logic byp0;
  logic byp1;

  assign fwd_ok = wr_ena && (wr_addr != 5'd0) && !rst;
  assign byp0   = fwd_ok && (rd_addr0 == wr_addr);
  assign byp1   = fwd_ok && (rd_addr1 == wr_addr);

  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    if (!rst) begin
      rd_data0 = byp0 ? wr_data : rd_store0;
      rd_data1 = byp1 ? wr_data : rd_store1;
    end
  end
`else
  // Stored contents only; a read in the write cycle sees the old value.
  // Outputs are forced to zero during reset independent of flop update timing.
  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    if (!rst) begin
      rd_data0 = rd_store0;
      rd_data1 = rd_store1;
    end
  end
`endif

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter N, default 32: width in bits of each register and of every data port.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port wr_ena, input, 1 bit: write enable.
REQ-005 SHALL have port wr_addr, input, 5 bits: write register index, 0-31.
REQ-006 SHALL have port wr_data, input, N bits: write data.
REQ-007 SHALL have port rd_addr0, input, 5 bits: read port 0 register index.
REQ-008 SHALL have port rd_data0, output, N bits: read port 0 data.
REQ-009 SHALL have port rd_addr1, input, 5 bits: read port 1 register index.
REQ-010 SHALL have port rd_data1, output, N bits: read port 1 data.

Function
REQ-011 SHALL hold 32 registers x00-x31 of N bits each.
REQ-012 SHALL decode wr_addr 5-to-32 into one-hot per-register enables, gated by wr_ena.
REQ-013 SHALL, on a rising clk with wr_ena=1 and wr_addr!=0, load wr_data into register wr_addr only; all other registers hold.
REQ-014 SHALL ignore writes to x00; x00 reads 0 at all times.
REQ-015 SHALL leave every register unchanged on a rising clk with wr_ena=0, regardless of wr_addr and wr_data.
REQ-016 SHALL drive rd_data0 and rd_data1 combinationally from the registers selected by rd_addr0 and rd_addr1; 0 cycles of read latency.
REQ-017 SHALL keep the two read ports fully independent; rd_addr0==rd_addr1 returns the same value on both.
REQ-018 SHALL make a write visible at the read ports from the clk edge that commits it; with the bypass feature out, a read in the write cycle returns the old value.
REQ-019 SHALL treat all wr_addr values 0-31 as legal; there is no out-of-range case and no wrap.
REQ-020 SHALL produce no X on the outputs while rd_addr0 and rd_addr1 are known; the register array SHALL contain no latches.

Reset
REQ-021 SHALL clear all 32 registers to 0 immediately when rst is asserted, independent of clk.
REQ-022 SHALL hold all registers at 0 while rst=1 and SHALL ignore writes during that time.
REQ-023 SHALL drive rd_data0 and rd_data1 to 0 during reset, for any read address.
REQ-024 SHALL discard any write in flight when rst rises; the first write after rst deasserts takes effect on the first rising clk with rst=0.

Configuration
REQ-025 SHALL support macro REGFILE_BYPASS_EN, which selects write-to-read forwarding.
REQ-026 SHALL, when REGFILE_BYPASS_EN is defined, drive wr_data combinationally onto rd_dataK when rd_addrK==wr_addr, wr_ena=1, wr_addr!=0 and rst=0 (same-cycle forwarding on each port independently).
REQ-027 SHALL, when REGFILE_BYPASS_EN is undefined, have no forwarding path; reads return stored contents only, as in REQ-018.

Verification
REQ-028 SHALL cover reset: assert rst mid-sequence after writing x05=32'hDEADBEEF -> rd_data0 at rd_addr0=5 reads 0 before the next clk edge, and all 32 registers read 0.
REQ-029 SHALL cover the write walk: write x(i)=i*32'h01010101 for i=1..31, then read every index on both ports -> each returns its own value and x00 returns 0.
REQ-030 SHALL cover x00 protection: write x00=32'hFFFFFFFF with wr_ena=1 -> rd_data0 at rd_addr0=0 stays 0.
REQ-031 SHALL cover disabled writes: wr_ena=0, wr_addr=7, wr_data=32'h12345678 -> x07 keeps its prior value.
REQ-032 SHALL cover same-cycle read/write: x03 holds 32'hAAAA0000; write x03=32'h0000BBBB while rd_addr0=rd_addr1=3 -> in that cycle both ports read 32'h0000BBBB with REGFILE_BYPASS_EN and 32'hAAAA0000 without; after the edge both read 32'h0000BBBB.
REQ-033 SHALL cover the width parameter: with N=8, write x31=8'hA5 -> rd_data1 at rd_addr1=31 reads 8'hA5.
